pipe_skid_stage: RTL and testbench



---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_data_reg.sv | 29 ++
 rtl/pipe_skid_stage.sv | 134 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid stage: state encoding and occupancy codes.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Number of valid entries held in a given state.
  function automatic logic [1:0] occ_of_state(input pipe_state_t s);
    logic [1:0] occ;
    occ = OCC_EMPTY;
    case (s)
      EMPTY:   occ = OCC_EMPTY;
      BUSY:    occ = OCC_BUSY;
      FULL:    occ = OCC_FULL;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register: async reset, synchronous clear, load enable.
// Clear wins over load so a flush can scrub the register in the same edge.
module pipe_data_reg #(
  parameter int WIDTH = 151
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Hold unless loaded or cleared; reset forces zero immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with a two-entry skid buffer.
//
//   state | meaning
//   EMPTY | no payload held; out_valid=0
//   BUSY  | main register holds the head payload
//   FULL  | main holds head, skid holds the next payload; in_ready=0
//
// in_ready, out_valid and occupancy are decodes of the state register only,
// so neither out_ready nor in_valid reaches any output combinationally.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH          = 151,
  parameter bit CLEAR_ON_FLUSH = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             softReset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_t      r_state;
  pipe_state_t      w_state_next;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_load;
  logic             w_main_from_skid;
  logic             w_skid_load;
  logic             w_clear;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign in_ready   = (r_state != FULL);
  assign out_valid  = (r_state != EMPTY);
  assign occupancy  = occ_of_state(r_state);
  assign out_data   = w_main_q;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Data registers are only scrubbed on flush when the build asks for it.
  assign w_clear    = softReset & CLEAR_ON_FLUSH;

  // Main refills from skid when draining FULL, otherwise from upstream.
  assign w_main_d   = w_main_from_skid ? w_skid_q : in_data;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and register-load steering.
  always_comb begin
    w_state_next     = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;

    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_state_next = BUSY;
          w_main_load  = 1'b1;
        end
      end
      BUSY: begin
        case ({w_in_fire, w_out_fire})
          2'b11: begin
            w_main_load = 1'b1;
          end
          2'b10: begin
            w_state_next = FULL;
            w_skid_load  = 1'b1;
          end
          2'b01: begin
            w_state_next = EMPTY;
          end
          default: begin
          end
        endcase
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (w_out_fire) begin
          w_state_next     = BUSY;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase

    // Squash: drop everything held and the payload offered this cycle.
    if (softReset) begin
      w_state_next     = EMPTY;
      w_main_load      = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_load      = 1'b0;
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk     (clk),
    .rst     (reset),
    .i_load  (w_main_load),
    .i_clear (w_clear),
    .i_d     (w_main_d),
    .o_q     (w_main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .rst     (reset),
    .i_load  (w_skid_load),
    .i_clear (w_clear),
    .i_d     (in_data),
    .o_q     (w_skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: two instances (flush holds data / flush clears
// data) driven by the same stimulus, a queue model as scoreboard, a vector
// table for directed sequences, and a random bubble run.
module tb_pipe_skid_stage;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         softReset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         in_ready0, out_valid0, in_ready1, out_valid1;
  logic [W-1:0] out_data0, out_data1;
  logic [1:0]   occupancy0, occupancy1;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] sb[$];

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         s;
    logic [1:0]   occ;
    logic         ov;
    logic         ir;
    logic [W-1:0] od1;
    logic [W-1:0] od0;
  } vec_t;

  vec_t vecs[$];

  pipe_skid_stage #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .softReset (softReset),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_data  (out_data0),
    .occupancy (occupancy0)
  );

  pipe_skid_stage #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .softReset (softReset),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .occupancy (occupancy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic r,
                              input logic s, input logic [1:0] occ, input logic ov,
                              input logic ir, input logic [W-1:0] od1,
                              input logic [W-1:0] od0);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.s = s;
    t.occ = occ; t.ov = ov; t.ir = ir; t.od1 = od1; t.od0 = od0;
    return t;
  endfunction

  // One clock of stimulus, entered and left at a negedge. Checks both DUTs
  // against the queue model, probes for combinational in_valid/out_ready
  // paths, then advances the model by what should fire at the posedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic s);
    int   sz;
    logic ir_before;
    logic ov_before;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    softReset = s;
    #1;
    sz = sb.size();
    chk("sb_occupancy", 32'(occupancy1), 32'(sz));
    chk("sb_occupancy_c0", 32'(occupancy0), 32'(sz));
    chk("sb_in_ready", 32'(in_ready1), 32'(sz != 2));
    chk("sb_out_valid", 32'(out_valid1), 32'(sz != 0));
    if (sz != 0) begin
      chk("sb_out_data", 32'(out_data1), 32'(sb[0]));
      chk("sb_out_data_c0", 32'(out_data0), 32'(sb[0]));
    end
    ir_before = in_ready1;
    ov_before = out_valid1;
    out_ready = ~r;
    in_valid  = ~v;
    #1;
    chk("in_ready_comb", 32'(in_ready1), 32'(ir_before));
    chk("out_valid_comb", 32'(out_valid1), 32'(ov_before));
    out_ready = r;
    in_valid  = v;
    #1;
    if (sz != 0 && r) void'(sb.pop_front());
    if (v && sz != 2) sb.push_back(d);
    if (s) sb.delete();
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid1), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready1), 32'd1);
    chk({tag, "_occupancy"}, 32'(occupancy1), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data1), 32'd0);
    chk({tag, "_out_data_c0"}, 32'(out_data0), 32'd0);
    chk({tag, "_occupancy_c0"}, 32'(occupancy0), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    softReset = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    // streaming at full rate
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1'b1, 8'(i), 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'(i), 8'(i)));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h08, 8'h08));
    // back-pressure into FULL, offer while FULL, then drain in order
    vecs.push_back(mk(1'b1, 8'h11, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 8'h11, 8'h11));
    vecs.push_back(mk(1'b1, 8'h22, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 8'h11, 8'h11));
    vecs.push_back(mk(1'b1, 8'h33, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 8'h11, 8'h11));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 8'h11, 8'h11));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'h22, 8'h22));
    vecs.push_back(mk(1'b1, 8'h33, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'h33, 8'h33));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h33, 8'h33));
    // flush from BUSY with both sides firing
    vecs.push_back(mk(1'b1, 8'h44, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 8'h44, 8'h44));
    vecs.push_back(mk(1'b1, 8'h55, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 8'h00, 8'h44));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 8'h44));
    // flush from FULL
    vecs.push_back(mk(1'b1, 8'h66, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 8'h66, 8'h66));
    vecs.push_back(mk(1'b1, 8'h77, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 8'h66, 8'h66));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 8'h00, 8'h66));
    vecs.push_back(mk(1'b1, 8'h88, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 8'h88, 8'h88));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h88, 8'h88));

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].s);
      chk($sformatf("vec%0d_occupancy", i), 32'(occupancy1), 32'(vecs[i].occ));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid1), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready1), 32'(vecs[i].ir));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data1), 32'(vecs[i].od1));
      chk($sformatf("vec%0d_out_data_c0", i), 32'(out_data0), 32'(vecs[i].od0));
    end

    // async reset while FULL, asserted mid-cycle
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    step(1'b1, 8'h0B, 1'b0, 1'b0);
    chk("pre_reset_occupancy", 32'(occupancy1), 32'd2);
    chk("pre_reset_out_data", 32'(out_data1), 32'h0A);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    in_valid  = 1'b1;
    in_data   = 8'h0C;
    out_ready = 1'b1;
    softReset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("held_reset");
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    step(1'b1, 8'h0C, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // random bubbles with occasional flush
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained_occupancy", 32'(occupancy1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
